// File: rtl/eth_rx_pkg.sv
// eth_rx_pkg: shared constants and state encoding for the GMII receive path
package eth_rx_pkg;
  localparam logic [7:0] ETH_PREAMBLE = 8'h55;
  localparam logic [7:0] ETH_SFD = 8'hD5;
  localparam logic [31:0] CRC32_POLY = 32'hEDB88320;
  localparam logic [31:0] CRC32_INIT = 32'hFFFFFFFF;
  localparam logic [31:0] CRC32_RESIDUE = 32'hDEBB20E3;
  typedef enum logic [2:0] {IDLE, PRE, DATA, TRUNC, DROP} rx_state_t;
endpackage

// File: rtl/crc32_d8.sv
// crc32_d8: byte-wide reflected CRC-32 next-state function, LSB first
module crc32_d8
  import eth_rx_pkg::*;
(
  input  logic [31:0] crc,
  input  logic [7:0]  data,
  output logic [31:0] crc_next
);
  always_comb begin
    crc_next = crc;
    for (int i = 0; i < 8; i++) crc_next = (crc_next >> 1) ^ ((crc_next[0] ^ data[i]) ? CRC32_POLY : 32'h0);
  end
endmodule

// File: rtl/rx_gmii_framer.sv
// rx_gmii_framer: strips preamble/SFD, checks CRC-32 and length, removes FCS
module rx_gmii_framer
  import eth_rx_pkg::*;
#(
  parameter int MIN_PRE = 6,
  parameter int MIN_LEN = 64,
  parameter int MAX_LEN = 1518
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rx_dv,
  input  logic        rx_er,
  input  logic [7:0]  rxd,
  output logic        rx_en_out,
  output logic [7:0]  rxdata_out,
  output logic        frame_done,
  output logic        crc_ok,
  output logic [15:0] frame_cnt,
  output logic [15:0] err_cnt
);
  logic dv_r, er_r, err, cap, emit, done, ok;
  logic [7:0] d_r;
  logic [3:0] pre_cnt;
  logic [10:0] cnt;
  logic [31:0] crc, crc_next;
  logic [3:0][7:0] dl;
  rx_state_t state, state_n;

  crc32_d8 u_crc (.crc(crc), .data(d_r), .crc_next(crc_next));

  always_comb begin
    state_n = state;
    case (state)
      IDLE: state_n = !dv_r ? IDLE : d_r == ETH_PREAMBLE ? PRE : DROP;
      PRE: state_n = !dv_r ? IDLE : d_r == ETH_PREAMBLE ? PRE :
                     (d_r == ETH_SFD && pre_cnt >= 4'(MIN_PRE)) ? DATA : DROP;
      DATA: state_n = !dv_r ? IDLE : cnt >= 11'(MAX_LEN) ? TRUNC : DATA;
      default: state_n = dv_r ? state : IDLE;
    endcase
  end

  assign cap = state == DATA && dv_r && cnt < 11'(MAX_LEN);
  // the delay line holds the last 4 bytes, so output lags capture by exactly the FCS length
  assign emit = cap && cnt >= 11'd4;
  assign done = (state == DATA || state == TRUNC) && !dv_r;
  assign ok = state == DATA && crc == CRC32_RESIDUE && cnt >= 11'(MIN_LEN) && cnt <= 11'(MAX_LEN) && !err;

  always_ff @(posedge clk) begin
    if (rst) begin
      dv_r <= 1'b0;
      er_r <= 1'b0;
      d_r <= '0;
      state <= IDLE;
      pre_cnt <= '0;
      cnt <= '0;
      err <= 1'b0;
      crc <= CRC32_INIT;
      dl <= '0;
      rx_en_out <= 1'b0;
      rxdata_out <= '0;
      frame_done <= 1'b0;
      crc_ok <= 1'b0;
      frame_cnt <= '0;
      err_cnt <= '0;
    end else begin
      dv_r <= rx_dv;
      er_r <= rx_er;
      d_r <= rxd;
      state <= state_n;
      pre_cnt <= state == IDLE ? 4'd1 : pre_cnt + 4'(pre_cnt != 4'hF);
      if (state == PRE && state_n == DATA) begin
        cnt <= '0;
        err <= 1'b0;
        crc <= CRC32_INIT;
      end else if (cap) begin
        cnt <= cnt + 11'(cnt != '1);
        err <= err | er_r;
        crc <= crc_next;
        dl <= {dl[2:0], d_r};
      end
      rx_en_out <= emit;
      rxdata_out <= emit ? dl[3] : '0;
      frame_done <= done;
      crc_ok <= done && ok;
      frame_cnt <= frame_cnt + 16'(done);
      err_cnt <= err_cnt + 16'(done && !ok);
    end
  end
endmodule

// File: tb/tb_rx_gmii_framer.sv
// tb_rx_gmii_framer: randomized frames checked against a byte-level framing model
module tb_rx_gmii_framer;
  localparam int MIN_LEN = 13;
  localparam int MAX_LEN = 1518;
  typedef logic [7:0] bq_t[$];

  logic clk = 0, rst = 1, rx_dv = 0, rx_er = 0;
  logic [7:0] rxd = 0;
  logic rx_en_out, frame_done, crc_ok;
  logic [7:0] rxdata_out;
  logic [15:0] frame_cnt, err_cnt;

  int vectors = 0, miscompares = 0;
  int cyc = 0, t_first, t_drop, first_en, last_en, done_cyc, en_n;
  int exp_fc = 0, exp_ec = 0;
  bq_t got_q;
  logic ok_q[$];

  rx_gmii_framer #(.MIN_PRE(6), .MIN_LEN(MIN_LEN), .MAX_LEN(MAX_LEN)) dut (
    .clk(clk), .rst(rst), .rx_dv(rx_dv), .rx_er(rx_er), .rxd(rxd),
    .rx_en_out(rx_en_out), .rxdata_out(rxdata_out), .frame_done(frame_done),
    .crc_ok(crc_ok), .frame_cnt(frame_cnt), .err_cnt(err_cnt)
  );

  always #4 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (rx_en_out) begin
      got_q.push_back(rxdata_out);
      if (first_en < 0) first_en = cyc;
      last_en = cyc;
      en_n++;
    end
    if (frame_done) begin
      ok_q.push_back(crc_ok);
      done_cyc = cyc;
    end
  end

  // standard Ethernet FCS: reflected CRC-32 with final inversion
  function automatic logic [31:0] crc_calc(input bq_t p);
    logic [31:0] c = 32'hFFFFFFFF;
    foreach (p[i]) for (int j = 0; j < 8; j++) c = (c[0] ^ p[i][j]) ? (c >> 1) ^ 32'hEDB88320 : c >> 1;
    return ~c;
  endfunction

  function automatic void make_good(input int len, output bq_t p);
    logic [31:0] c;
    p = {};
    repeat (len - 4) p.push_back(8'($urandom));
    c = crc_calc(p);
    for (int j = 0; j < 4; j++) p.push_back(c[8*j +: 8]);
  endfunction

  function automatic void build(input int npre, input bq_t p, output bq_t s);
    s = {};
    repeat (npre) s.push_back(8'h55);
    s.push_back(8'hD5);
    foreach (p[i]) s.push_back(p[i]);
  endfunction

  // expected payload: first min(n,MAX_LEN)-4 bytes; good only if FCS matches body, length in range, no error
  function automatic void model(input bq_t p, input bit er, output bq_t e, output logic ok);
    int n = p.size();
    int keep = n > MAX_LEN ? MAX_LEN : n;
    bq_t body;
    e = {};
    for (int i = 0; i < keep - 4; i++) e.push_back(p[i]);
    ok = 1'b0;
    if (n >= MIN_LEN && n <= MAX_LEN && !er) begin
      for (int i = 0; i < n - 4; i++) body.push_back(p[i]);
      ok = crc_calc(body) == {p[n-1], p[n-2], p[n-3], p[n-4]};
    end
  endfunction

  task automatic clear_mon();
    got_q = {};
    ok_q = {};
    first_en = -1;
    last_en = -1;
    done_cyc = -1;
    en_n = 0;
  endtask

  task automatic drive(input bq_t s, input int first_idx, input int er_idx, input int gap);
    for (int i = 0; i < s.size(); i++) begin
      @(posedge clk); #1;
      rx_dv = 1;
      rxd = s[i];
      rx_er = (i == er_idx);
      if (i == first_idx) t_first = cyc;
    end
    @(posedge clk); #1;
    rx_dv = 0;
    rx_er = 0;
    rxd = 0;
    t_drop = cyc;
    repeat (gap - 1) @(posedge clk);
  endtask

  function automatic void known(output bq_t p);
    p = {};
    for (int i = 0; i < 9; i++) p.push_back(8'h31 + 8'(i));
    p.push_back(8'h26); p.push_back(8'h39); p.push_back(8'hF4); p.push_back(8'hCB);
  endfunction

  task automatic test_reset();
    vectors++; if ({rx_en_out, rxdata_out, frame_done, crc_ok} !== 11'h0) begin miscompares++; $display("FAIL reset_out got %h exp 0", {rx_en_out, rxdata_out, frame_done, crc_ok}); end
    vectors++; if ({frame_cnt, err_cnt} !== 32'h0) begin miscompares++; $display("FAIL reset_cnt got %h exp 0", {frame_cnt, err_cnt}); end
  endtask

  task automatic test_known();
    bq_t p, s;
    known(p); build(7, p, s); clear_mon();
    drive(s, 8, -1, 10);
    exp_fc++;
    vectors++; if (en_n !== 9) begin miscompares++; $display("FAIL known_len got %0d exp 9", en_n); end
    for (int i = 0; i < 9 && i < got_q.size(); i++) begin
      vectors++; if (got_q[i] !== 8'h31 + 8'(i)) begin miscompares++; $display("FAIL known_byte%0d got %h exp %h", i, got_q[i], 8'h31 + 8'(i)); break; end
    end
    vectors++; if (first_en - t_first !== 6) begin miscompares++; $display("FAIL known_latency got %0d exp 6", first_en - t_first); end
    vectors++; if (done_cyc - last_en !== 1) begin miscompares++; $display("FAIL known_done_gap got %0d exp 1", done_cyc - last_en); end
    vectors++; if (done_cyc - t_drop !== 2) begin miscompares++; $display("FAIL known_done_time got %0d exp 2", done_cyc - t_drop); end
    vectors++; if (ok_q.size() !== 1) begin miscompares++; $display("FAIL known_dones got %0d exp 1", ok_q.size()); end
    vectors++; if ((ok_q.size() > 0 ? ok_q[0] : 1'bx) !== 1'b1) begin miscompares++; $display("FAIL known_crc_ok got 0 exp 1"); end
    vectors++; if (frame_cnt !== 16'(exp_fc) || err_cnt !== 16'(exp_ec)) begin miscompares++; $display("FAIL known_cnt got %0d/%0d exp %0d/%0d", frame_cnt, err_cnt, exp_fc, exp_ec); end
  endtask

  task automatic test_bad_fcs();
    bq_t p, s;
    known(p); p[12] = 8'hCA; build(7, p, s); clear_mon();
    drive(s, 8, -1, 10);
    exp_fc++; exp_ec++;
    vectors++; if (en_n !== 9) begin miscompares++; $display("FAIL badfcs_len got %0d exp 9", en_n); end
    for (int i = 0; i < 9 && i < got_q.size(); i++) begin
      vectors++; if (got_q[i] !== 8'h31 + 8'(i)) begin miscompares++; $display("FAIL badfcs_byte%0d got %h exp %h", i, got_q[i], 8'h31 + 8'(i)); break; end
    end
    vectors++; if ((ok_q.size() == 1 ? ok_q[0] : 1'bx) !== 1'b0) begin miscompares++; $display("FAIL badfcs_crc_ok got %0d dones exp one with crc_ok=0", ok_q.size()); end
    vectors++; if (frame_cnt !== 16'(exp_fc) || err_cnt !== 16'(exp_ec)) begin miscompares++; $display("FAIL badfcs_cnt got %0d/%0d exp %0d/%0d", frame_cnt, err_cnt, exp_fc, exp_ec); end
  endtask

  task automatic test_rx_er();
    bq_t p, s;
    known(p); build(7, p, s); clear_mon();
    drive(s, 8, 8 + 4, 10);
    exp_fc++; exp_ec++;
    vectors++; if (en_n !== 9) begin miscompares++; $display("FAIL rxer_len got %0d exp 9", en_n); end
    for (int i = 0; i < 9 && i < got_q.size(); i++) begin
      vectors++; if (got_q[i] !== 8'h31 + 8'(i)) begin miscompares++; $display("FAIL rxer_byte%0d got %h exp %h", i, got_q[i], 8'h31 + 8'(i)); break; end
    end
    vectors++; if ((ok_q.size() == 1 ? ok_q[0] : 1'bx) !== 1'b0) begin miscompares++; $display("FAIL rxer_crc_ok got %0d dones exp one with crc_ok=0", ok_q.size()); end
    vectors++; if (err_cnt !== 16'(exp_ec)) begin miscompares++; $display("FAIL rxer_err_cnt got %0d exp %0d", err_cnt, exp_ec); end
  endtask

  task automatic test_short_preamble();
    bq_t p, s, e;
    logic ok;
    make_good(40, p); build(4, p, s); clear_mon();
    drive(s, 5, -1, 1);
    make_good(20, p); build(7, p, s);
    drive(s, 8, -1, 10);
    model(p, 1'b0, e, ok);
    exp_fc++;
    vectors++; if (ok_q.size() !== 1) begin miscompares++; $display("FAIL drop_dones got %0d exp 1", ok_q.size()); end
    vectors++; if ((ok_q.size() > 0 ? ok_q[0] : 1'bx) !== ok) begin miscompares++; $display("FAIL drop_next_ok got %b exp %b", ok_q.size() > 0 ? ok_q[0] : 1'bx, ok); end
    vectors++; if (got_q.size() !== e.size()) begin miscompares++; $display("FAIL drop_len got %0d exp %0d", got_q.size(), e.size()); end
    for (int i = 0; i < e.size() && i < got_q.size(); i++) begin
      vectors++; if (got_q[i] !== e[i]) begin miscompares++; $display("FAIL drop_byte%0d got %h exp %h", i, got_q[i], e[i]); break; end
    end
    vectors++; if (frame_cnt !== 16'(exp_fc) || err_cnt !== 16'(exp_ec)) begin miscompares++; $display("FAIL drop_cnt got %0d/%0d exp %0d/%0d", frame_cnt, err_cnt, exp_fc, exp_ec); end
  endtask

  task automatic test_short_frames();
    bq_t p, s, e, all;
    logic ok;
    int lens[5] = '{0, 1, 2, 3, 12};
    clear_mon(); all = {};
    foreach (lens[k]) begin
      if (lens[k] < 4) begin p = {}; repeat (lens[k]) p.push_back(8'($urandom)); end
      else make_good(lens[k], p);
      build(7, p, s);
      model(p, 1'b0, e, ok);
      foreach (e[i]) all.push_back(e[i]);
      exp_fc++; if (!ok) exp_ec++;
      drive(s, 8, -1, 1);
    end
    repeat (10) @(posedge clk);
    vectors++; if (ok_q.size() !== 5) begin miscompares++; $display("FAIL short_dones got %0d exp 5", ok_q.size()); end
    foreach (ok_q[i]) begin
      vectors++; if (ok_q[i] !== 1'b0) begin miscompares++; $display("FAIL short_ok%0d got %b exp 0", i, ok_q[i]); end
    end
    vectors++; if (got_q.size() !== all.size()) begin miscompares++; $display("FAIL short_len got %0d exp %0d", got_q.size(), all.size()); end
    vectors++; if (frame_cnt !== 16'(exp_fc) || err_cnt !== 16'(exp_ec)) begin miscompares++; $display("FAIL short_cnt got %0d/%0d exp %0d/%0d", frame_cnt, err_cnt, exp_fc, exp_ec); end
  endtask

  task automatic test_random();
    bq_t p, s, e, all;
    logic ok;
    logic okx[$];
    int len, np, er_idx;
    clear_mon(); all = {}; okx = {};
    for (int f = 0; f < 12; f++) begin
      len = int'($urandom_range(MIN_LEN, 90));
      make_good(len, p);
      if ($urandom_range(0, 3) == 0) p[$urandom_range(0, len - 1)] ^= 8'($urandom_range(1, 255));
      er_idx = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, len - 1)) : -1;
      np = int'($urandom_range(6, 20));
      build(np, p, s);
      model(p, er_idx >= 0, e, ok);
      foreach (e[i]) all.push_back(e[i]);
      okx.push_back(ok);
      exp_fc++; if (!ok) exp_ec++;
      drive(s, np + 1, er_idx < 0 ? -1 : np + 1 + er_idx, int'($urandom_range(1, 3)));
    end
    repeat (10) @(posedge clk);
    vectors++; if (ok_q.size() !== okx.size()) begin miscompares++; $display("FAIL rand_dones got %0d exp %0d", ok_q.size(), okx.size()); end
    for (int i = 0; i < okx.size() && i < ok_q.size(); i++) begin
      vectors++; if (ok_q[i] !== okx[i]) begin miscompares++; $display("FAIL rand_ok%0d got %b exp %b", i, ok_q[i], okx[i]); end
    end
    vectors++; if (got_q.size() !== all.size()) begin miscompares++; $display("FAIL rand_len got %0d exp %0d", got_q.size(), all.size()); end
    for (int i = 0; i < all.size() && i < got_q.size(); i++) begin
      vectors++; if (got_q[i] !== all[i]) begin miscompares++; $display("FAIL rand_byte%0d got %h exp %h", i, got_q[i], all[i]); break; end
    end
    vectors++; if (frame_cnt !== 16'(exp_fc) || err_cnt !== 16'(exp_ec)) begin miscompares++; $display("FAIL rand_cnt got %0d/%0d exp %0d/%0d", frame_cnt, err_cnt, exp_fc, exp_ec); end
  endtask

  task automatic test_trunc();
    bq_t p, s, e;
    logic ok;
    p = {};
    repeat (1600) p.push_back(8'($urandom));
    build(7, p, s); model(p, 1'b0, e, ok); clear_mon();
    drive(s, 8, -1, 10);
    exp_fc++; exp_ec++;
    vectors++; if (en_n !== 1514) begin miscompares++; $display("FAIL trunc_en_cycles got %0d exp 1514", en_n); end
    for (int i = 0; i < e.size() && i < got_q.size(); i++) begin
      vectors++; if (got_q[i] !== e[i]) begin miscompares++; $display("FAIL trunc_byte%0d got %h exp %h", i, got_q[i], e[i]); break; end
    end
    vectors++; if ((ok_q.size() == 1 ? ok_q[0] : 1'bx) !== 1'b0) begin miscompares++; $display("FAIL trunc_crc_ok got %0d dones exp one with crc_ok=0", ok_q.size()); end
    vectors++; if (done_cyc <= t_drop) begin miscompares++; $display("FAIL trunc_done_time got %0d exp after %0d", done_cyc, t_drop); end
    vectors++; if (err_cnt !== 16'(exp_ec)) begin miscompares++; $display("FAIL trunc_err_cnt got %0d exp %0d", err_cnt, exp_ec); end
  endtask

  task automatic test_rst_mid();
    bq_t p, s;
    int r = 8 + 20;
    make_good(64, p); build(7, p, s); clear_mon();
    for (int i = 0; i < s.size(); i++) begin
      @(posedge clk); #1;
      if (i == r + 1) begin
        vectors++; if ({rx_en_out, rxdata_out, frame_done, crc_ok, frame_cnt, err_cnt} !== 43'h0) begin miscompares++; $display("FAIL rst_outputs got %h exp 0", {rx_en_out, rxdata_out, frame_done, crc_ok, frame_cnt, err_cnt}); end
      end
      rst = (i == r);
      rx_dv = 1;
      rxd = s[i];
    end
    @(posedge clk); #1;
    rx_dv = 0; rxd = 0;
    repeat (10) @(posedge clk);
    exp_fc = 0; exp_ec = 0;
    vectors++; if (ok_q.size() !== 0) begin miscompares++; $display("FAIL rst_no_done got %0d exp 0", ok_q.size()); end
    make_good(64, p); build(7, p, s); clear_mon();
    drive(s, 8, -1, 10);
    exp_fc++;
    vectors++; if ((ok_q.size() == 1 ? ok_q[0] : 1'bx) !== 1'b1) begin miscompares++; $display("FAIL rst_next_ok got %0d dones exp one with crc_ok=1", ok_q.size()); end
    vectors++; if (got_q.size() !== 60) begin miscompares++; $display("FAIL rst_next_len got %0d exp 60", got_q.size()); end
    vectors++; if (frame_cnt !== 16'(exp_fc) || err_cnt !== 16'(exp_ec)) begin miscompares++; $display("FAIL rst_next_cnt got %0d/%0d exp %0d/%0d", frame_cnt, err_cnt, exp_fc, exp_ec); end
  endtask

  initial begin
    clear_mon();
    repeat (3) @(posedge clk);
    #1 rst = 0;
    test_reset();
    test_known();
    test_bad_fcs();
    test_rx_er();
    test_short_preamble();
    test_short_frames();
    test_random();
    test_trunc();
    test_rst_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
